radiant_trig_config_master: RTL and testbench

Wishbone initiator that programs one trigger slot of the RADIANT trigger-control register block. On a start pulse it runs a fixed bus sequence: master disable, write the four per-trigger registers, read them back and compare, then re-enable. It sits between the board-manager command decoder and the trigger-core Wishbone slave port. Because that slave accepts per-trigger writes only while master enable is off, this block owns the disable/configure/re-enable ordering.

---
 rtl/radiant_trig_config_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_radiant_trig_config_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radiant_trig_config_master.sv
// radiant_trig_config_master
// Wishbone initiator that programs one trigger slot of the RADIANT
// trigger-control block. The sequence is: master disable, write the four
// slot registers, read them back and compare, then master re-enable.
// The re-enable is skipped on any readback mismatch or bus fault, which
// leaves the trigger core disabled.

module radiant_trig_config_master #(
   parameter  int NUM_TRIG      = 4,
   parameter  int NUM_CH        = 24,
   parameter  int ONESHOT_WIDTH = 20,
   parameter  int THRESH_WIDTH  = 5,
   parameter  int TIMEOUT       = 255,
   localparam int TW            = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   // command side
   input  logic                     start_i,
   input  logic [TW-1:0]            trig_idx_i,
   input  logic                     trig_en_i,
   input  logic [NUM_CH-1:0]        maskb_i,
   input  logic [ONESHOT_WIDTH-1:0] window_i,
   input  logic [THRESH_WIDTH-1:0]  thresh_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [1:0]               err_code_o,
   // Wishbone initiator
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic                     wb_we_o,
   output logic [8:0]               wb_adr_o,
   output logic [31:0]              wb_dat_o,
   output logic [3:0]               wb_sel_o,
   input  logic [31:0]              wb_dat_i,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i,
   input  logic                     wb_rty_i
);

   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   // Last ISSUE cycle allowed before giving up on the ack.
   localparam logic [TCW-1:0] TOUT_LAST = TCW'(TIMEOUT - 1);

   // Slot count at index width + 1 so NUM_TRIG == 2**TW still compares cleanly.
   localparam logic [TW:0] NUM_TRIG_W = NUM_TRIG[TW:0];

   // Step 0 is the disable write, 1..4 slot writes, 5..8 readbacks, 9 re-enable.
   localparam logic [3:0] STEP_LAST_WR   = 4'd4;
   localparam logic [3:0] STEP_LAST_READ = 4'd8;
   localparam logic [3:0] STEP_ENABLE    = 4'd9;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISMATCH = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_BUS      = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP,
      S_DONE
   } state_t;

   // Configuration captured at start, so the command side may change freely.
   typedef struct packed {
      logic [TW-1:0]            idx;
      logic                     en;
      logic [NUM_CH-1:0]        maskb;
      logic [ONESHOT_WIDTH-1:0] window;
      logic [THRESH_WIDTH-1:0]  thresh;
   } cfg_t;

   state_t          state_q;
   logic [3:0]      step_q;
   logic [3:0]      step_nxt;
   logic [TCW-1:0]  tout_q;
   logic            mism_q;
   cfg_t            cfg_q;
   logic [31:0]     rd_exp;

   // Word k (0..3) of the slot register group, zero-extended to the bus width.
   function automatic logic [31:0] cfg_word(input cfg_t c, input logic [1:0] k);
      logic [31:0] w;
      w = '0;
      case (k)
         2'd0: w = {c.en, 31'b0};
         2'd1: w = 32'(c.maskb);
         2'd2: w = 32'(c.window);
         2'd3: w = 32'(c.thresh);
         default: w = '0;
      endcase
      return w;
   endfunction

   // Byte address of a step: global control at 0x000, slot group at 0x100 + 16*idx.
   // Writes (1..4) and reads (5..8) walk the same four offsets.
   function automatic logic [8:0] step_adr(input cfg_t c, input logic [3:0] s);
      logic [3:0] k;
      logic [8:0] a;
      k = s - 4'd1;
      a = 9'h100 + 9'({c.idx, 4'b0000}) + 9'({k[1:0], 2'b00});
      if (s == 4'd0 || s == STEP_ENABLE) a = '0;
      return a;
   endfunction

   function automatic logic step_we(input logic [3:0] s);
      return (s <= STEP_LAST_WR) || (s == STEP_ENABLE);
   endfunction

   function automatic logic [31:0] step_dat(input cfg_t c, input logic [3:0] s);
      logic [31:0] d;
      d = '0;
      if (s == STEP_ENABLE)
         d = 32'd1;
      else if (s >= 4'd1 && s <= STEP_LAST_WR)
         d = cfg_word(c, 2'(s - 4'd1));
      return d;
   endfunction

   assign step_nxt = step_q + 4'd1;

   // Readback steps 5..8 map onto words 0..3 through the same step-1 offset.
   assign rd_exp = cfg_word(cfg_q, 2'(step_q - 4'd1));

   // Sequencer: one transaction per ISSUE, a single idle GAP between them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         tout_q     <= '0;
         mism_q     <= 1'b0;
         cfg_q      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_code_o <= ERR_OK;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_sel_o   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  cfg_q  <= '{idx: trig_idx_i, en: trig_en_i, maskb: maskb_i,
                              window: window_i, thresh: thresh_i};
                  step_q <= '0;
                  tout_q <= '0;
                  mism_q <= 1'b0;
                  if ({1'b0, trig_idx_i} >= NUM_TRIG_W) begin
                     // Nonexistent slot: report without touching the bus.
                     state_q    <= S_DONE;
                     done_o     <= 1'b1;
                     err_code_o <= ERR_BUS;
                  end else begin
                     // Step 0: master disable, constant address and data.
                     state_q    <= S_ISSUE;
                     err_code_o <= ERR_OK;
                     busy_o     <= 1'b1;
                     wb_cyc_o   <= 1'b1;
                     wb_stb_o   <= 1'b1;
                     wb_we_o    <= 1'b1;
                     wb_adr_o   <= '0;
                     wb_dat_o   <= '0;
                     wb_sel_o   <= 4'hF;
                  end
               end
            end

            S_ISSUE: begin
               if (wb_err_i || wb_rty_i) begin
                  // Bus fault beats a coincident ack.
                  state_q    <= S_DONE;
                  done_o     <= 1'b1;
                  busy_o     <= 1'b0;
                  err_code_o <= ERR_BUS;
                  wb_cyc_o   <= 1'b0;
                  wb_stb_o   <= 1'b0;
                  wb_we_o    <= 1'b0;
                  wb_adr_o   <= '0;
                  wb_dat_o   <= '0;
                  wb_sel_o   <= '0;
               end else if (wb_ack_i) begin
                  // A bad readback is remembered; the remaining reads still run.
                  if (!wb_we_o && (wb_dat_i != rd_exp)) mism_q <= 1'b1;
                  state_q  <= S_GAP;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= '0;
                  wb_dat_o <= '0;
                  wb_sel_o <= '0;
               end else if (tout_q == TOUT_LAST) begin
                  state_q    <= S_DONE;
                  done_o     <= 1'b1;
                  busy_o     <= 1'b0;
                  err_code_o <= ERR_TIMEOUT;
                  wb_cyc_o   <= 1'b0;
                  wb_stb_o   <= 1'b0;
                  wb_we_o    <= 1'b0;
                  wb_adr_o   <= '0;
                  wb_dat_o   <= '0;
                  wb_sel_o   <= '0;
               end else begin
                  tout_q <= tout_q + 1'b1;
               end
            end

            S_GAP: begin
               // Acks arriving here are the target's repeated ack and are dropped.
               if (step_q == STEP_ENABLE) begin
                  state_q    <= S_DONE;
                  done_o     <= 1'b1;
                  busy_o     <= 1'b0;
                  err_code_o <= ERR_OK;
               end else if (step_q == STEP_LAST_READ && mism_q) begin
                  // Leave the trigger core disabled.
                  state_q    <= S_DONE;
                  done_o     <= 1'b1;
                  busy_o     <= 1'b0;
                  err_code_o <= ERR_MISMATCH;
               end else begin
                  state_q  <= S_ISSUE;
                  step_q   <= step_nxt;
                  tout_q   <= '0;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= step_we(step_nxt);
                  wb_adr_o <= step_adr(cfg_q, step_nxt);
                  wb_dat_o <= step_dat(cfg_q, step_nxt);
                  wb_sel_o <= 4'hF;
               end
            end

            S_DONE: begin
               // start_i seen here is intentionally lost.
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_radiant_trig_config_master.sv
// tb_radiant_trig_config_master
// Randomized bench: a Wishbone target model with programmable wait states,
// faults and stray acks, plus a sequence-level reference model that predicts
// the transaction list, completion cycle and result code.

module tb_radiant_trig_config_master;

   localparam int NUM_TRIG = 3;
   localparam int NUM_CH   = 24;
   localparam int OW       = 20;
   localparam int THW      = 5;
   localparam int TIMEOUT  = 8;
   localparam int TW       = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [TW-1:0]     trig_idx = '0;
   logic              trig_en = 1'b0;
   logic [NUM_CH-1:0] maskb = '0;
   logic [OW-1:0]     window = '0;
   logic [THW-1:0]    thresh = '0;
   logic              busy, done;
   logic [1:0]        err_code;
   logic              wb_cyc, wb_stb, wb_we;
   logic [8:0]        wb_adr;
   logic [31:0]       wb_dat_o;
   logic [3:0]        wb_sel;
   logic [31:0]       s_rdat = '0;
   logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

   radiant_trig_config_master #(
      .NUM_TRIG(NUM_TRIG), .NUM_CH(NUM_CH), .ONESHOT_WIDTH(OW),
      .THRESH_WIDTH(THW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .trig_idx_i(trig_idx),
      .trig_en_i(trig_en), .maskb_i(maskb), .window_i(window), .thresh_i(thresh),
      .busy_o(busy), .done_o(done), .err_code_o(err_code),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(s_rdat),
      .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- target model knobs (written only by the stimulus) ----
   int          wait_tbl [16];
   int          err_txn, rty_txn, noack_txn;
   logic [8:0]  corrupt_adr;
   logic [31:0] corrupt_xor;
   bit          stray_en;

   // ---------------- Wishbone target model ----------------
   logic [31:0] mem [0:127];
   int          wcnt = 0, txn = 0;
   bit          stray_pend = 0;

   always @(posedge clk) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_rty <= 1'b0;
      if (rst || (start && !busy)) begin
         wcnt <= 0;
         txn <= 0;
         stray_pend <= 0;
      end else if (stray_pend) begin
         s_ack <= 1'b1;
         stray_pend <= 0;
      end else if (wb_cyc && wb_stb && !s_ack && txn != noack_txn) begin
         if (wcnt < wait_tbl[txn]) wcnt <= wcnt + 1;
         else begin
            wcnt <= 0;
            txn <= txn + 1;
            if (txn == rty_txn) s_rty <= 1'b1;
            else begin
               s_ack <= 1'b1;
               stray_pend <= stray_en;
               if (txn == err_txn) s_err <= 1'b1;
               else if (wb_we) mem[wb_adr[8:2]] <= wb_dat_o;
               else s_rdat <= mem[wb_adr[8:2]] ^ ((wb_adr == corrupt_adr) ? corrupt_xor : 32'h0);
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   typedef struct packed {
      logic [8:0]  adr;
      logic        we;
      logic [31:0] dat;
   } txn_t;

   txn_t obs_q[$];
   txn_t cur;
   logic cyc_prev = 1'b0;

   always @(negedge clk) begin
      if (wb_cyc && !cyc_prev) begin
         cur = '{adr: wb_adr, we: wb_we, dat: wb_dat_o};
         obs_q.push_back(cur);
      end else if (wb_cyc) begin
         chk("bus_stable", {wb_adr, wb_we, wb_dat_o}, cur);
      end
      chk("strobes", {wb_stb, wb_sel}, wb_cyc ? 5'h1F : 5'h00);
      cyc_prev = wb_cyc;
   end

   task automatic clean_knobs();
      for (int i = 0; i < 16; i++) wait_tbl[i] = 0;
      err_txn = -1; rty_txn = -1; noack_txn = -1;
      corrupt_adr = 9'h1FF; corrupt_xor = 32'h0; stray_en = 0;
   endtask

   // mode: 0 plain, 1 extra start while busy, 2 start during done, 3 reset at cycle 10
   task automatic run_seq(input logic [1:0] idx, input logic en, input logic [23:0] mb,
                          input logic [19:0] win, input logic [4:0] th, input int mode,
                          output int done_at, output logic [1:0] err_at_done);
      txn_t        exp_q[$];
      txn_t        e;
      logic [31:0] words [4];
      int          exp_err, exp_done, t, base, base_n, n_done, last;
      bit          mm;

      // reference model: walk the programming steps with their wait states
      exp_done = -1;
      exp_err  = 0;
      if (idx >= NUM_TRIG) begin
         exp_err = 3;
         exp_done = 1;
      end else begin
         base = 'h100 + 16 * idx;
         words[0] = {en, 31'b0};
         words[1] = 32'(mb);
         words[2] = 32'(win);
         words[3] = 32'(th);
         t = 1;
         mm = 0;
         for (int s = 0; s < 10 && exp_done < 0; s++) begin
            if (s == 9 && mm) begin
               exp_err = 1;
               exp_done = t;
            end else begin
               if (s == 0)      e = '{adr: 9'h000, we: 1'b1, dat: 32'h0};
               else if (s <= 4) e = '{adr: 9'(base + 4 * (s - 1)), we: 1'b1, dat: words[s - 1]};
               else if (s <= 8) e = '{adr: 9'(base + 4 * (s - 5)), we: 1'b0, dat: 32'h0};
               else             e = '{adr: 9'h000, we: 1'b1, dat: 32'h1};
               exp_q.push_back(e);
               if (s == err_txn || s == rty_txn) begin
                  exp_err = 3;
                  exp_done = t + wait_tbl[s] + 2;
               end else if (s == noack_txn) begin
                  exp_err = 2;
                  exp_done = t + TIMEOUT;
               end else begin
                  if (s >= 5 && s <= 8 && e.adr == corrupt_adr && corrupt_xor != 0) mm = 1;
                  t += wait_tbl[s] + 3;
               end
            end
         end
         if (exp_done < 0) exp_done = t;
      end

      base_n = obs_q.size();
      done_at = -1;
      err_at_done = 2'bxx;
      n_done = 0;
      last = (mode == 3) ? 45 : exp_done + 2;

      @(negedge clk);
      trig_idx = idx; trig_en = en; maskb = mb; window = win; thresh = th;
      start = 1'b1;
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            trig_idx = TW'($urandom); trig_en = 1'($urandom);
            maskb = NUM_CH'($urandom); window = OW'($urandom); thresh = THW'($urandom);
         end
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = n;
         end
         if (mode != 3 && n < exp_done) chk("busy_run", busy, exp_q.size() > 0);
         if (mode != 3 && n == exp_done) begin
            chk("busy_at_done", busy, 0);
            err_at_done = err_code;
            chk("err_code", err_code, exp_err);
         end
         if (mode != 3 && n == exp_done + 2) chk("err_held", err_code, exp_err);
         if (mode == 1 && n == 5) start = 1'b1;
         if (mode == 1 && n == 6) start = 1'b0;
         if (mode == 2 && n == exp_done) begin
            trig_idx = 2'd0;
            start = 1'b1;
         end
         if (mode == 2 && n == exp_done + 1) begin
            start = 1'b0;
            chk("done_start_cyc", wb_cyc, 0);
            chk("done_start_busy", busy, 0);
         end
         if (mode == 2 && n == exp_done + 2) chk("done_start_cyc2", wb_cyc, 0);
         if (mode == 3 && n == 10) rst = 1'b1;
         if (mode == 3 && n == 11) begin
            rst = 1'b0;
            chk("rst_mid_outs", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, busy, done, err_code}, 0);
         end
      end

      if (mode == 3) begin
         chk("rst_mid_no_done", n_done, 0);
      end else begin
         chk("done_cycle", done_at, exp_done);
         chk("done_pulses", n_done, 1);
         chk("txn_count", obs_q.size() - base_n, exp_q.size());
         for (int i = 0; i < exp_q.size() && i < obs_q.size() - base_n; i++) begin
            chk($sformatf("txn%0d_adr", i), obs_q[base_n + i].adr, exp_q[i].adr);
            chk($sformatf("txn%0d_we", i), obs_q[base_n + i].we, exp_q[i].we);
            if (exp_q[i].we) chk($sformatf("txn%0d_dat", i), obs_q[base_n + i].dat, exp_q[i].dat);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int          d;
      logic [1:0]  ec;
      logic [1:0]  ridx;
      int          f;

      clean_knobs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, busy, done, err_code}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {wb_cyc, busy, done, err_code}, 0);

      // nominal
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("nominal_done31", d, 31);
      chk("nominal_err0", ec, 0);

      // readback mismatch at 0x124 -> 0x00ABCDEE
      corrupt_adr = 9'h124; corrupt_xor = 32'h1;
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("mismatch_done28", d, 28);
      chk("mismatch_err1", ec, 1);
      clean_knobs();

      // step 3 never acked
      noack_txn = 3;
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("timeout_done18", d, 18);
      chk("timeout_err2", ec, 2);
      clean_knobs();

      // err coincident with ack on step 1
      err_txn = 1;
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("buserr_done6", d, 6);
      chk("buserr_err3", ec, 3);
      clean_knobs();

      // nonexistent slot
      run_seq(2'd3, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("badidx_done1", d, 1);
      chk("badidx_err3", ec, 3);

      // repeated ack in every GAP
      stray_en = 1;
      run_seq(2'd1, 1'b1, 24'h123456, 20'hFEDCB, 5'd31, 0, d, ec);
      chk("stray_done31", d, 31);
      clean_knobs();

      run_seq(2'd0, 1'b0, 24'h00F00F, 20'h00001, 5'd1, 1, d, ec);
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 2, d, ec);
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 3, d, ec);
      run_seq(2'd2, 1'b1, 24'hABCDEF, 20'h12345, 5'd9, 0, d, ec);
      chk("after_rst_done31", d, 31);

      // randomized sequences
      for (int it = 0; it < 30; it++) begin
         clean_knobs();
         ridx = 2'($urandom_range(0, 3));
         for (int i = 0; i < 10; i++) wait_tbl[i] = $urandom_range(0, 3);
         stray_en = 1'($urandom);
         f = $urandom_range(0, 5);
         if (f == 2) begin
            corrupt_adr = 9'('h100 + 16 * ridx + 4 * $urandom_range(0, 3));
            corrupt_xor = 32'h1 << $urandom_range(0, 31);
         end else if (f == 3) err_txn = $urandom_range(0, 9);
         else if (f == 4) rty_txn = $urandom_range(0, 9);
         else if (f == 5) noack_txn = $urandom_range(0, 9);
         run_seq(ridx, 1'($urandom), 24'($urandom), 20'($urandom), 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, d, ec);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
